// File: rtl/vga_draw_arbiter_if.sv
// Bus bundle between drawing clients and the VGA draw arbiter.
// master: the client/testbench side; slave: the arbiter side.
interface vga_draw_arbiter_if #(
    parameter int NUM_CLIENTS = 3,
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int COLOR_W     = 3
);
    logic [NUM_CLIENTS-1:0]         req;
    logic [NUM_CLIENTS-1:0]         done;
    logic [NUM_CLIENTS-1:0]         plot_in;
    logic [NUM_CLIENTS*X_W-1:0]     x_in;
    logic [NUM_CLIENTS*Y_W-1:0]     y_in;
    logic [NUM_CLIENTS*COLOR_W-1:0] color_in;
    logic [NUM_CLIENTS-1:0]         grant;
    logic                           plot;
    logic [X_W-1:0]                 X;
    logic [Y_W-1:0]                 Y;
    logic [COLOR_W-1:0]             color;
    logic                           busy;
    logic                           timeout;

    modport master (
        output req, done, plot_in, x_in, y_in, color_in,
        input  grant, plot, X, Y, color, busy, timeout
    );

    modport slave (
        input  req, done, plot_in, x_in, y_in, color_in,
        output grant, plot, X, Y, color, busy, timeout
    );
endinterface

// File: rtl/vga_draw_arbiter.sv
// VGA draw arbiter: round-robin ownership of a single VGA adapter write port
// among NUM_CLIENTS drawing clients, with registered, clipped pixel writes.
// Optional feature: define ARB_WATCHDOG_EN to add an ownership watchdog that
// revokes a grant after WDT_CYCLES owned cycles without an owner pixel write.
module vga_draw_arbiter #(
    parameter int NUM_CLIENTS = 3,
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int COLOR_W     = 3,
    parameter int X_MAX       = 320,
    parameter int Y_MAX       = 240,
    parameter int WDT_CYCLES  = 1024
) (
    input  logic                clock,
    input  logic                reset,
    vga_draw_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_CLIENTS);
    localparam logic [X_W:0] X_LIM = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(Y_MAX);
    localparam logic [NUM_CLIENTS-1:0] ONE_HOT0 = {{(NUM_CLIENTS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t                 state_r, state_s;
    logic [IDX_W-1:0]       owner_r, owner_s;
    logic [IDX_W-1:0]       last_r, last_s;
    logic [NUM_CLIENTS-1:0] grant_r, grant_s;
    logic                   busy_r, busy_s;
    logic                   timeout_r, timeout_s;
    logic                   plot_r, plot_s;
    logic [X_W-1:0]         x_r, x_s;
    logic [Y_W-1:0]         y_r, y_s;
    logic [COLOR_W-1:0]     color_r, color_s;

    logic [IDX_W-1:0]       winner_s;
    logic                   win_found_s;
    logic                   release_s;
    logic                   owner_plot_s;
    logic                   wdt_expire_s;
    logic [X_W-1:0]         own_x_s;
    logic [Y_W-1:0]         own_y_s;
    logic [COLOR_W-1:0]     own_color_s;

    // The owner gives up the port when it signals done or drops its request.
    assign release_s    = bus.done[owner_r] | ~bus.req[owner_r];
    assign owner_plot_s = bus.plot_in[owner_r];
    assign own_x_s      = bus.x_in[owner_r*X_W +: X_W];
    assign own_y_s      = bus.y_in[owner_r*Y_W +: Y_W];
    assign own_color_s  = bus.color_in[owner_r*COLOR_W +: COLOR_W];

    // Round-robin search: first requester starting just after the last owner.
    always_comb begin
        int idx;
        idx         = 0;
        winner_s    = last_r;
        win_found_s = 1'b0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            idx = (int'(last_r) + k) % NUM_CLIENTS;
            if (!win_found_s && bus.req[idx]) begin
                win_found_s = 1'b1;
                winner_s    = IDX_W'(idx);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt_r, wdt_cnt_s;

    // Watchdog: restart on every owner pixel write, expire after WDT_CYCLES quiet owned cycles.
    always_comb begin
        wdt_cnt_s    = wdt_cnt_r;
        wdt_expire_s = 1'b0;
        if (state_r == ST_OWNED) begin
            if (owner_plot_s) begin
                wdt_cnt_s = '0;
            end else if (wdt_cnt_r == WDT_LAST) begin
                wdt_expire_s = 1'b1;
                wdt_cnt_s    = '0;
            end else begin
                wdt_cnt_s = wdt_cnt_r + WDT_W'(1);
            end
        end else begin
            // Held at zero while idle so every fresh grant starts counting from zero.
            wdt_cnt_s = '0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            wdt_cnt_r <= '0;
        end else begin
            wdt_cnt_r <= wdt_cnt_s;
        end
    end
`else
    assign wdt_expire_s = 1'b0;
`endif

    // Ownership FSM next-state: IDLE -> OWNED on a winner, OWNED -> IDLE on release or expiry.
    always_comb begin
        state_s   = state_r;
        owner_s   = owner_r;
        last_s    = last_r;
        grant_s   = grant_r;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_s = ST_OWNED;
                    owner_s = winner_s;
                    grant_s = ONE_HOT0 << winner_s;
                end else begin
                    grant_s = '0;
                end
            end
            ST_OWNED: begin
                if (release_s) begin
                    state_s = ST_IDLE;
                    last_s  = owner_r;
                    grant_s = '0;
                end else if (wdt_expire_s) begin
                    state_s   = ST_IDLE;
                    last_s    = owner_r;
                    grant_s   = '0;
                    timeout_s = 1'b1;
                end else begin
                    grant_s = grant_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = '0;
            end
        endcase
        busy_s = |grant_s;
    end

    // Pixel path: follow the owner's inputs while owned, clip off-screen writes, hold when idle.
    always_comb begin
        if (state_r == ST_OWNED) begin
            x_s     = own_x_s;
            y_s     = own_y_s;
            color_s = own_color_s;
            plot_s  = owner_plot_s && ({1'b0, own_x_s} < X_LIM) && ({1'b0, own_y_s} < Y_LIM);
        end else begin
            x_s     = x_r;
            y_s     = y_r;
            color_s = color_r;
            plot_s  = 1'b0;
        end
    end

    // State and output registers; last starts at the top index so client 0 wins first.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            owner_r   <= '0;
            last_r    <= IDX_W'(NUM_CLIENTS - 1);
            grant_r   <= '0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            plot_r    <= 1'b0;
            x_r       <= '0;
            y_r       <= '0;
            color_r   <= '0;
        end else begin
            state_r   <= state_s;
            owner_r   <= owner_s;
            last_r    <= last_s;
            grant_r   <= grant_s;
            busy_r    <= busy_s;
            timeout_r <= timeout_s;
            plot_r    <= plot_s;
            x_r       <= x_s;
            y_r       <= y_s;
            color_r   <= color_s;
        end
    end

    assign bus.grant   = grant_r;
    assign bus.busy    = busy_r;
    assign bus.timeout = timeout_r;
    assign bus.plot    = plot_r;
    assign bus.X       = x_r;
    assign bus.Y       = y_r;
    assign bus.color   = color_r;
endmodule

// File: doc/vga_draw_arbiter.md
VGA_DRAW_ARBITER -- requirements
Module: vga_draw_arbiter

Interface
REQ-001 Parameter: NUM_CLIENTS, default 3, number of drawing clients (2..8).
REQ-002 Parameter: X_W, default 9, X coordinate width.
REQ-003 Parameter: Y_W, default 8, Y coordinate width.
REQ-004 Parameter: COLOR_W, default 3, color width.
REQ-005 Parameter: X_MAX, default 320, first illegal X value.
REQ-006 Parameter: Y_MAX, default 240, first illegal Y value.
REQ-007 Parameter: WDT_CYCLES, default 1024, watchdog limit (used only under the macro).
REQ-008 Port: clock  input  1  single system clock; all logic on its rising edge.
REQ-009 Port: reset  input  1  synchronous, active-high reset.
REQ-010 Port: req  input  NUM_CLIENTS  per-client request for the VGA port.
REQ-011 Port: done  input  NUM_CLIENTS  per-client end-of-drawing strobe.
REQ-012 Port: plot_in  input  NUM_CLIENTS  per-client pixel-write strobe.
REQ-013 Port: x_in  input  NUM_CLIENTS*X_W  packed X coordinates; client i at bits [i*X_W +: X_W].
REQ-014 Port: y_in  input  NUM_CLIENTS*Y_W  packed Y coordinates, same packing.
REQ-015 Port: color_in  input  NUM_CLIENTS*COLOR_W  packed colors, same packing.
REQ-016 Port: grant  output  NUM_CLIENTS  one-hot or zero ownership indication.
REQ-017 Port: plot, X, Y, color  output  1/X_W/Y_W/COLOR_W  registered VGA adapter write.
REQ-018 Port: busy  output  1  high while any grant is active.
REQ-019 Port: timeout  output  1  one-cycle pulse on watchdog revocation.

Function
REQ-020 States SHALL be IDLE and OWNED; grant SHALL be zero in IDLE and exactly one-hot in OWNED.
REQ-021 In IDLE with any req bit high, the winner SHALL be the first requesting index searched from (last+1) mod NUM_CLIENTS upward with wrap; grant is asserted and state moves to OWNED on the next edge.
REQ-022 In OWNED, owner g SHALL release when done[g]=1 or req[g]=0; grant clears and state returns to IDLE on the next edge, and last is set to g.
REQ-023 At least one IDLE cycle SHALL separate consecutive grants, including re-grant to the same client.
REQ-024 In OWNED, X/Y/color SHALL register the owner's x_in/y_in/color_in each cycle, and plot SHALL register plot_in[g]: latency of exactly 1 cycle.
REQ-025 plot SHALL be 0 when registered X >= X_MAX or Y >= Y_MAX (clip); X/Y/color still update.
REQ-026 plot_in from non-owners SHALL be ignored; in IDLE, plot SHALL be 0 and X/Y/color SHALL hold.
REQ-027 A plot_in[g] asserted in the same cycle as done[g] SHALL still be forwarded.
REQ-028 busy SHALL equal the OR of grant.

Reset
REQ-029 On reset high at any edge, including mid-ownership: state IDLE, grant 0, plot 0, X 0, Y 0, color 0, busy 0, timeout 0, watchdog count 0, last NUM_CLIENTS-1 (client 0 wins first).
REQ-030 Requests present during reset SHALL be arbitrated only from the first edge after reset deasserts.

Configuration
REQ-031 With ARB_WATCHDOG_EN defined, a counter SHALL clear on grant and on every owner plot_in, increment otherwise in OWNED, and on reaching WDT_CYCLES revoke the grant (to IDLE, last=g) with timeout high for exactly that one cycle.
REQ-032 Without ARB_WATCHDOG_EN, no counter SHALL exist, timeout SHALL be constant 0, and ownership ends only per REQ-022.

Verification
REQ-033 After reset, req=3'b111 -> grant 3'b001 one cycle later; done[0] -> IDLE cycle, then grant 3'b010, then 3'b100, then 3'b001.
REQ-034 Owner 1 plot_in=1, x_in=100, y_in=50, color=3'b101 -> next cycle plot=1, X=100, Y=50, color=3'b101; client 2 plot_in ignored.
REQ-035 Owner drives X=320,Y=10 then X=319,Y=239 -> plot 0 then 1.
REQ-036 reset pulsed mid-OWNED with plot active -> all outputs 0 next edge; with req=3'b110 re-arbitration grants 3'b010.
REQ-037 ARB_WATCHDOG_EN, WDT_CYCLES=16, owner holds req with no plot_in -> grant drops after 16 OWNED cycles, timeout pulses 1 cycle, next requester is granted.
REQ-038 Single requester req=3'b100 releasing and re-requesting -> grant 3'b100 each time with one IDLE cycle between.
